ks_adder_pipe: RTL

KS_ADDER_PIPE -- requirements
Module: ks_adder_pipe

---
 rtl/ks_adder_pipe_if.sv | 47 ++++
 rtl/ks_adder_pipe.sv | 130 +++++++++++++
 2 files changed

// File: rtl/ks_adder_pipe_if.sv
// rtl/ks_adder_pipe_if.sv - Operand/result handshake bundle for ks_adder_pipe; adds in_sub when KSA_SUB_EN is defined
interface ks_adder_pipe_if #(
  parameter int WIDTH = 16
);
  // Operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
`ifdef KSA_SUB_EN
  logic             in_sub;
`endif

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

`ifdef KSA_SUB_EN
  // Adder side of the bundle
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  // Producer/consumer side of the bundle
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`else
  // Adder side of the bundle
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  // Producer/consumer side of the bundle
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
`endif
endinterface

// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - Pipelined Kogge-Stone adder with valid/ready flow control; KSA_SUB_EN enables in_sub subtraction
module ks_adder_pipe #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  ks_adder_pipe_if.slave bus
);

  // Prefix depth and register-stage count (stage 0 plus one register per level)
  localparam int LVL = $clog2(WIDTH);
  localparam int LAT = LVL + 1;

  // Whole pipeline advances together; a stalled output freezes every stage
  logic en;

  // Per-stage valid bits (index LVL is the output stage)
  logic [LAT-1:0]   v_q;
  logic [LAT-1:0]   v_d;

  // Group generate per stage; stage LVL holds the final carries C[i]
  logic [WIDTH-1:0] g_q  [LAT];
  logic [WIDTH-1:0] g_d  [LAT];

  // Group propagate; the last level never needs one, so only LVL entries
  logic [WIDTH-1:0] p_q  [LVL];
  logic [WIDTH-1:0] p_d  [LVL];

  // Original bitwise propagate and carry-in, carried along for the sum
  logic [WIDTH-1:0] po_q [LAT];
  logic [WIDTH-1:0] po_d [LAT];
  logic [LAT-1:0]   cin_q;
  logic [LAT-1:0]   cin_d;

  // Operands after optional subtract conditioning
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_c;

  // Stage-0 bitwise terms
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;

  // Final carries and raw sum before valid gating
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;

  // Condition operands: subtraction is a + ~b + 1, ignoring the carry-in
  always_comb begin
    op_a = bus.in_a;
    op_b = bus.in_b;
    op_c = bus.in_cin;
`ifdef KSA_SUB_EN
    if (bus.in_sub) begin
      op_b = ~bus.in_b;
      op_c = 1'b1;
    end
`endif
  end

  // Next-state for every stage: bitwise terms, then the prefix levels
  always_comb begin
    // Stage 0: bitwise G/P with the carry-in folded into bit 0
    g0       = op_a & op_b;
    p0       = op_a ^ op_b;
    g0[0]    = g0[0] | (p0[0] & op_c);
    g_d[0]   = g0;
    p_d[0]   = p0;
    po_d[0]  = p0;
    cin_d[0] = op_c;
    v_d[0]   = bus.in_valid;

    // Levels 1..LVL: black-box cells at distance 2^(k-1), grey-box pass-through below it
    for (int k = 1; k <= LVL; k++) begin
      g_d[k] = g_q[k-1];
      for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
        g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
      end
      po_d[k]  = po_q[k-1];
      cin_d[k] = cin_q[k-1];
      v_d[k]   = v_q[k-1];
    end

    // Group propagate only matters for levels that feed another level
    for (int k = 1; k < LVL; k++) begin
      p_d[k] = p_q[k-1];
      for (int i = (1 << (k - 1)); i < WIDTH; i++) begin
        p_d[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k - 1))];
      end
    end
  end

  // Valid bits: cleared asynchronously, shifted only when the pipe advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else if (en) begin
      v_q <= v_d;
    end
  end

  // Data registers: no reset needed, contents of invalid stages are don't-care
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < LAT; k++) begin
        g_q[k]  <= g_d[k];
        po_q[k] <= po_d[k];
      end
      for (int k = 0; k < LVL; k++) begin
        p_q[k] <= p_d[k];
      end
      cin_q <= cin_d;
    end
  end

  // Sum from final carries: bit 0 uses the carry-in, bit i uses C[i-1]
  always_comb begin
    carry = g_q[LVL];
    sum   = po_q[LVL] ^ {carry[WIDTH-2:0], cin_q[LVL]};
  end

  // Flow control and valid-gated outputs
  assign en            = !v_q[LVL] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[LVL];
  assign bus.out_sum   = v_q[LVL] ? sum : '0;
  assign bus.out_cout  = v_q[LVL] & carry[WIDTH-1];
  assign bus.out_ovf   = v_q[LVL] & (carry[WIDTH-1] ^ carry[WIDTH-2]);

endmodule
